// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types, constants and counter helper for branch_ctrl
package branch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] SNT       = 2'b00;
  localparam logic [1:0] WNT       = 2'b01;
  localparam logic [1:0] WT        = 2'b10;
  localparam logic [1:0] ST        = 2'b11;
  localparam logic [1:0] BHT_RESET = WNT;

  localparam logic [31:0] PC_RESET = 32'h0;

  // 2-bit saturating counter step: toward ST when taken, toward SNT otherwise.
  function automatic logic [1:0] sat2_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'b01;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// rtl/branch_bht.sv - bimodal history table, one async read port and one sync update port
module branch_bht
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] bht_q [BHT_ENTRIES];
  logic [1:0] bht_d [BHT_ENTRIES];

  // Read is straight from the flops, so an update lands on the next cycle's read.
  assign rd_ctr = bht_q[rd_idx];

  // Next-state of the table: only the trained entry moves.
  always_comb begin
    bht_d = bht_q;
    if (upd_en) bht_d[upd_idx] = sat2_update(bht_q[upd_idx], upd_taken);
  end

  // Table storage; every entry restarts weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_RESET;
    end else begin
      bht_q <= bht_d;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch prediction, resolution, redirect/flush control and perf counters
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic [31:0]      id_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic             ex_taken,
  input  logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             ctrl_busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W  = $clog2(BHT_ENTRIES);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_CYCLES - 1);

  logic [IDX_W-1:0]  id_idx, ex_idx;
  logic [1:0]        id_ctr;
  logic              res, br_res, mispred, do_redirect;
  logic [31:0]       tgt;
  logic              unused_pc_bits;

  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              redirect_q, redirect_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  assign id_idx         = id_pc[IDX_W+1:2];
  assign ex_idx         = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{id_pc[31:IDX_W+2], id_pc[1:0]};

  branch_bht #(.BHT_ENTRIES(BHT_ENTRIES)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (id_idx),
    .rd_ctr    (id_ctr),
    .upd_en    (br_res),
    .upd_idx   (ex_idx),
    .upd_taken (ex_taken)
  );

  assign pred_taken = id_valid & id_is_branch & id_ctr[1];

  // Resolution decode: EX is only trusted in RUN and when not frozen; jumps win over branches.
  always_comb begin
    res         = ex_valid & ~stall & (state_q == RUN);
    br_res      = res & ex_is_branch & ~ex_is_jump;
    mispred     = br_res & (ex_taken != ex_pred_taken);
    do_redirect = (res & ex_is_jump) | mispred;
    if (ex_is_jump || ex_taken) tgt = ex_target;
    else                        tgt = ex_pc + 32'd4;
  end

  // FSM next-state: a redirect opens a fixed-length flush window.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    flush_d       = flush_q;
    busy_d        = busy_q;
    redirect_d    = do_redirect;
    redirect_pc_d = do_redirect ? tgt : redirect_pc_q;
    case (state_q)
      RUN: begin
        if (do_redirect) begin
          state_d = FLUSH;
          fcnt_d  = '0;
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_q == FCNT_LAST) begin
          state_d = RUN;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        flush_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Saturating performance counters for resolved and mispredicted branches.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (br_res && (branch_cnt_q != '1))   branch_cnt_d  = branch_cnt_q + CNT_W'(1);
    if (mispred && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  // FSM state, registered control outputs and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      fcnt_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= PC_RESET;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush       = flush_q;
  assign ctrl_busy   = busy_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl with a behavioural reference model
module tb_branch_ctrl;

  localparam int N_BHT   = 16;
  localparam int FLUSH_N = 2;
  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_is_branch;
  logic [31:0] id_pc;
  logic        pred_taken;
  logic        ex_valid, ex_is_branch, ex_is_jump;
  logic [31:0] ex_pc, ex_target;
  logic        ex_pred_taken, ex_taken, stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush, ctrl_busy;
  logic [15:0] branch_cnt, mispred_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_bht [N_BHT];
  int          m_bcnt, m_mcnt, m_flush_left;
  bit          m_redirect;
  logic [31:0] m_rpc;

  always #5 clk = ~clk;

  branch_ctrl #(.BHT_ENTRIES(N_BHT), .FLUSH_CYCLES(FLUSH_N), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_is_branch  (id_is_branch),
    .id_pc         (id_pc),
    .pred_taken    (pred_taken),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_is_jump    (ex_is_jump),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_taken      (ex_taken),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .ctrl_busy     (ctrl_busy),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  task automatic model_reset();
    for (int i = 0; i < N_BHT; i++) m_bht[i] = 1;
    m_bcnt = 0; m_mcnt = 0; m_flush_left = 0; m_redirect = 0; m_rpc = 32'h0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit in_fl, res, nr;
    logic [31:0] npc;
    int i;
    in_fl = (m_flush_left > 0);
    res   = ex_valid && !stall && !in_fl;
    nr    = 0;
    npc   = m_rpc;
    if (res && ex_is_jump) begin
      nr = 1; npc = ex_target;
    end else if (res && ex_is_branch) begin
      i = int'(ex_pc[5:2]);
      if (ex_taken) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
      else          m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
      if (m_bcnt < CNT_MAX) m_bcnt++;
      if (ex_taken != ex_pred_taken) begin
        if (m_mcnt < CNT_MAX) m_mcnt++;
        nr  = 1;
        npc = ex_taken ? ex_target : ex_pc + 32'd4;
      end
    end
    if (in_fl) m_flush_left--;
    if (nr) m_flush_left = FLUSH_N;
    m_redirect = nr;
    m_rpc      = npc;
  endtask

  function automatic bit model_pred(input logic [31:0] pc);
    return m_bht[int'(pc[5:2])] >= 2;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_pc = 0;
    ex_target = 0; ex_pred_taken = 0; ex_taken = 0; stall = 0;
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [31:0] tg, input logic pr, input logic tk);
    ex_valid = 1; ex_is_branch = 1; ex_is_jump = 0; ex_pc = pc;
    ex_target = tg; ex_pred_taken = pr; ex_taken = tk;
  endtask

  task automatic test_reset();
    rst_n = 0; id_valid = 0; id_is_branch = 0; id_pc = 0;
    clear_ex();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if ({redirect, flush, ctrl_busy} !== 3'b000 || redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: redirect=%b flush=%b busy=%b rpc=%h, want 0 0 0 0", redirect, flush, ctrl_busy, redirect_pc);
    end
    checks++;
    if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: branch=%0d mispred=%0d, want 0 0", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_mispredict_taken();
    id_valid = 1; id_is_branch = 1; id_pc = 32'h40;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL pred_init: got %b want 0", pred_taken); end
    set_br(32'h40, 32'h100, 1'b0, 1'b1);
    tick();
    clear_ex();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin
      errors++; $display("FAIL mp_redirect: redirect=%b rpc=%h, want 1 00000100", redirect, redirect_pc);
    end
    checks++;
    if (flush !== 1'b1 || ctrl_busy !== 1'b1) begin
      errors++; $display("FAIL mp_flush1: flush=%b busy=%b, want 1 1", flush, ctrl_busy);
    end
    checks++;
    if (branch_cnt !== 16'd1 || mispred_cnt !== 16'd1) begin
      errors++; $display("FAIL mp_cnt: branch=%0d mispred=%0d, want 1 1", branch_cnt, mispred_cnt);
    end
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL mp_bht_wt: pred=%b want 1", pred_taken); end
    tick();
    checks++;
    if (redirect !== 1'b0 || flush !== 1'b1) begin
      errors++; $display("FAIL mp_flush2: redirect=%b flush=%b, want 0 1", redirect, flush);
    end
    tick();
    checks++;
    if (flush !== 1'b0 || ctrl_busy !== 1'b0 || redirect_pc !== 32'h100) begin
      errors++; $display("FAIL mp_flush_end: flush=%b busy=%b rpc=%h, want 0 0 00000100", flush, ctrl_busy, redirect_pc);
    end
  endtask

  task automatic test_not_taken_correct();
    set_br(32'h40, 32'h100, 1'b0, 1'b0);
    tick();
    clear_ex();
    checks++;
    if (redirect !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL nt_noredirect: redirect=%b flush=%b, want 0 0", redirect, flush);
    end
    checks++;
    if (branch_cnt !== 16'd2 || mispred_cnt !== 16'd1) begin
      errors++; $display("FAIL nt_cnt: branch=%0d mispred=%0d, want 2 1", branch_cnt, mispred_cnt);
    end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL nt_bht_down: pred=%b want 0", pred_taken); end
  endtask

  task automatic test_wrap();
    set_br(32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b0);
    tick();
    clear_ex();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_pc: redirect=%b rpc=%h, want 1 00000000", redirect, redirect_pc);
    end
    checks++;
    if (branch_cnt !== 16'd3 || mispred_cnt !== 16'd2) begin
      errors++; $display("FAIL wrap_cnt: branch=%0d mispred=%0d, want 3 2", branch_cnt, mispred_cnt);
    end
    tick(); tick();
  endtask

  task automatic test_jump();
    ex_valid = 1; ex_is_jump = 1; ex_is_branch = 1; ex_pc = 32'h80;
    ex_target = 32'h200; ex_taken = 1; ex_pred_taken = 0;
    tick();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200 || flush !== 1'b1) begin
      errors++; $display("FAIL jal_redirect: redirect=%b rpc=%h flush=%b, want 1 00000200 1", redirect, redirect_pc, flush);
    end
    checks++;
    if (branch_cnt !== 16'd3 || mispred_cnt !== 16'd2) begin
      errors++; $display("FAIL jal_cnt: branch=%0d mispred=%0d, want 3 2", branch_cnt, mispred_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      set_br(32'h84, 32'h999, 1'b0, 1'b1);
      tick();
      checks++;
      if (redirect !== 1'b0 || redirect_pc !== 32'h200 || branch_cnt !== 16'd3 || mispred_cnt !== 16'd2) begin
        errors++;
        $display("FAIL jal_wrongpath%0d: redirect=%b rpc=%h branch=%0d mispred=%0d, want 0 00000200 3 2",
                 k, redirect, redirect_pc, branch_cnt, mispred_cnt);
      end
    end
    clear_ex();
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL jal_flush_end: flush=%b want 0", flush); end
  endtask

  task automatic test_stall();
    set_br(32'h48, 32'h300, 1'b0, 1'b1);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (redirect !== 1'b0 || flush !== 1'b0 || branch_cnt !== 16'd3) begin
        errors++; $display("FAIL stall_hold%0d: redirect=%b flush=%b branch=%0d, want 0 0 3", k, redirect, flush, branch_cnt);
      end
    end
    stall = 0;
    tick();
    clear_ex();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h300 || branch_cnt !== 16'd4 || mispred_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stall_release: redirect=%b rpc=%h branch=%0d mispred=%0d, want 1 00000300 4 3",
               redirect, redirect_pc, branch_cnt, mispred_cnt);
    end
    tick();
    checks++;
    if (redirect !== 1'b0) begin errors++; $display("FAIL stall_pulse: redirect=%b want 0", redirect); end
    tick();
  endtask

  task automatic drain();
    for (int g = 0; g < 10 && m_flush_left > 0; g++) tick();
  endtask

  task automatic test_saturate();
    id_valid = 1; id_is_branch = 1; id_pc = 32'h4C;
    for (int k = 0; k < 5; k++) begin
      set_br(32'h4C, 32'h500, model_pred(32'h4C), 1'b1);
      tick();
      clear_ex();
      drain();
    end
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_taken: pred=%b want 1", pred_taken); end
    set_br(32'h4C, 32'h500, 1'b1, 1'b0);
    tick();
    clear_ex();
    checks++;
    if (pred_taken !== 1'b1 || redirect_pc !== 32'h50) begin
      errors++; $display("FAIL sat_capped: pred=%b rpc=%h, want 1 00000050", pred_taken, redirect_pc);
    end
    drain();
    set_br(32'h4C, 32'h500, 1'b1, 1'b0);
    tick();
    clear_ex();
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_down2: pred=%b want 0", pred_taken); end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_is_branch  = ($urandom_range(0, 3) != 0);
      id_pc         = {$urandom_range(0, 15), 2'b00};
      ex_valid      = ($urandom_range(0, 9) < 7);
      ex_is_jump    = ($urandom_range(0, 7) == 0);
      ex_is_branch  = ($urandom_range(0, 3) != 0);
      ex_pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 15), 2'b00};
      ex_target     = $urandom;
      ex_taken      = $urandom_range(0, 1);
      ex_pred_taken = ($urandom_range(0, 3) == 0) ? ~model_pred(ex_pc) : model_pred(ex_pc);
      stall         = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (pred_taken !== (id_valid & id_is_branch & model_pred(id_pc))) begin
        errors++; $display("FAIL rnd_pred@%0d: got %b want %b", n, pred_taken, id_valid & id_is_branch & model_pred(id_pc));
      end
      tick();
      checks++;
      if (redirect !== m_redirect || redirect_pc !== m_rpc || flush !== (m_flush_left > 0) ||
          ctrl_busy !== (m_flush_left > 0) || branch_cnt !== 16'(m_bcnt) || mispred_cnt !== 16'(m_mcnt)) begin
        errors++;
        $display("FAIL rnd_out@%0d: redirect=%b rpc=%h flush=%b busy=%b branch=%0d mispred=%0d, want %b %h %b %b %0d %0d",
                 n, redirect, redirect_pc, flush, ctrl_busy, branch_cnt, mispred_cnt,
                 m_redirect, m_rpc, m_flush_left > 0, m_flush_left > 0, m_bcnt, m_mcnt);
      end
    end
    clear_ex();
    drain();
  endtask

  task automatic test_reset_in_flush();
    id_valid = 1; id_is_branch = 1; id_pc = 32'h40;
    set_br(32'h40, 32'h100, 1'b0, 1'b1);
    while (model_pred(32'h40)) begin
      set_br(32'h40, 32'h100, 1'b1, 1'b0);
      tick(); clear_ex(); drain();
      set_br(32'h40, 32'h100, 1'b0, 1'b1);
    end
    tick();
    clear_ex();
    checks++;
    if (flush !== 1'b1 || pred_taken !== 1'b1) begin
      errors++; $display("FAIL rif_setup: flush=%b pred=%b, want 1 1", flush, pred_taken);
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (flush !== 1'b0 || ctrl_busy !== 1'b0 || redirect !== 1'b0 || branch_cnt !== 16'd0) begin
      errors++; $display("FAIL rif_abort: flush=%b busy=%b redirect=%b branch=%0d, want 0 0 0 0", flush, ctrl_busy, redirect, branch_cnt);
    end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL rif_bht_reset: pred=%b want 0", pred_taken); end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (flush !== 1'b0 || redirect_pc !== 32'h0) begin
      errors++; $display("FAIL rif_after: flush=%b rpc=%h, want 0 00000000", flush, redirect_pc);
    end
  endtask

  initial begin
    test_reset();
    test_mispredict_taken();
    test_not_taken_correct();
    test_wrap();
    test_jump();
    test_stall();
    test_saturate();
    test_random();
    test_reset_in_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch resolution and control-hazard controller for the 5-stage RV32I pipeline.
- ID side: gives a direction prediction from a small 2-bit bimodal history table (BHT).
- EX side: checks the prediction against the Branch_Comp result (ex_taken), trains the BHT, and redirects the PC on a mispredict or jump.
- Drives the pipeline flush for a fixed number of cycles and keeps performance counters.

Parameters:
- BHT_ENTRIES, 16, number of 2-bit counters; power of 2, at least 2. IDX_W = log2(BHT_ENTRIES).
- FLUSH_CYCLES, 2, cycles flush is held after a redirect; at least 1.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_is_branch  in  1  ID instruction is a conditional branch.
- id_pc  in  32  PC of the ID instruction.
- pred_taken  out  1  prediction for the ID branch (combinational).
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_is_jump  in  1  EX instruction is JAL or JALR.
- ex_pc  in  32  PC of the EX instruction.
- ex_target  in  32  computed branch/jump target.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_taken  in  1  branch_taken from Branch_Comp.
- stall  in  1  EX is frozen this cycle (load-use hazard).
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  corrected fetch PC.
- flush  out  1  squash IF/ID and ID/EX.
- ctrl_busy  out  1  high while in FLUSH.
- branch_cnt  out  CNT_W  number of resolved conditional branches.
- mispred_cnt  out  CNT_W  number of mispredicted conditional branches.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; redirect=0, redirect_pc=0, flush=0, ctrl_busy=0.
  - Both counters 0; every BHT entry = 2'b01 (weakly not-taken).
  - Reset mid-FLUSH aborts the flush immediately.
- BHT index = pc[IDX_W+1:2].
- pred_taken = id_valid & id_is_branch & bht[id_idx][1]. Combinational, no bypass: a same-cycle update to the same index is seen next cycle.
- Resolution event: res = ex_valid & ~stall & (state==RUN).
  - A stalled EX instruction resolves exactly once, on the cycle stall drops.
- Jumps:
  - res & ex_is_jump gives a redirect to ex_target.
  - Jumps are never predicted and do not touch the BHT or the counters.
  - ex_is_jump has priority if ex_is_branch is also set.
- Conditional branches (res & ex_is_branch & ~ex_is_jump):
  - BHT[ex_idx] saturating update: +1 if ex_taken (cap 2'b11), -1 otherwise (floor 2'b00).
  - branch_cnt += 1.
  - If ex_taken != ex_pred_taken: mispred_cnt += 1 and redirect, to ex_target if ex_taken else ex_pc+4 (mod 2^32).
- Counters saturate at all-ones; they do not wrap.
- Redirect timing:
  - redirect and redirect_pc are registered, so they appear the cycle after res.
  - redirect is high for exactly 1 cycle.
  - redirect_pc holds its value until the next redirect.
- FSM:
  - RUN: on a redirect-causing res, go to FLUSH and load fcnt=0.
  - FLUSH: flush=1 and ctrl_busy=1, both registered and entered together with redirect. fcnt increments each cycle; go to RUN after FLUSH_CYCLES cycles in FLUSH.
  - In FLUSH, EX contents are wrong-path: ex_* is ignored, with no BHT update, no counting and no new redirect.
  - stall does not extend FLUSH.
- Correctly predicted branches and non-branch instructions produce no flush or redirect.
- Back-to-back resolutions in RUN (one per cycle) are each handled. The first redirect-causing one moves to FLUSH, so the following cycle's EX is ignored.

Decomposition:
- Shared package branch_pkg holds:
  - the state enum {RUN, FLUSH};
  - the 2-bit counter constants (SNT=00, WNT=01, WT=10, ST=11, BHT_RESET=WNT);
  - a sat2_update(ctr, taken) function;
  - the reset constant PC_RESET=32'h0.
- One sub-module, branch_bht:
  - register array with async reset;
  - one combinational read port (ID) and one synchronous update port (EX);
  - parameterised by BHT_ENTRIES.
- FSM, redirect logic and counters live in branch_ctrl.

Test Plan:
- Reset, then ID branch at pc=0x40 -> pred_taken=0. Taken branch in EX at pc=0x40 with ex_pred_taken=0 and ex_target=0x100 -> next cycle redirect=1 and redirect_pc=0x100; flush high 2 cycles; mispred_cnt=1, branch_cnt=1; BHT[0]=10.
- Same branch, not taken, with ex_pred_taken=0 -> no redirect or flush; BHT[0] goes down; branch_cnt increments, mispred_cnt does not.
- Predicted taken but not taken, ex_pc=0xFFFF_FFFC -> redirect_pc=0x0000_0000 (wrap).
- JAL at ex_pc=0x80 with ex_target=0x200, ex_valid=1 in the next two cycles -> one redirect to 0x200; the wrong-path EX instructions are ignored; counters unchanged.
- Mispredicting branch in EX with stall=1 for 3 cycles -> no action while stalled; exactly one redirect the cycle after stall drops.
- Four taken resolutions at one index -> BHT saturates at 11; a further taken resolution leaves it at 11. Assert rst_n low during FLUSH -> flush=0 immediately and BHT back to 01.
